// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port picorv32 memory arbiter with registered outputs and timeout watchdog
// Build option: MEM_ARBITER_ROUND_ROBIN_EN selects round-robin tie-break instead of fixed port-0 priority.
module mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,

   input  logic        s0_mem_valid,
   input  logic        s0_mem_instr,
   input  logic [31:0] s0_mem_addr,
   input  logic [31:0] s0_mem_wdata,
   input  logic [3:0]  s0_mem_wstrb,
   output logic        s0_mem_ready,
   output logic [31:0] s0_mem_rdata,
   output logic        s0_mem_err,

   input  logic        s1_mem_valid,
   input  logic        s1_mem_instr,
   input  logic [31:0] s1_mem_addr,
   input  logic [31:0] s1_mem_wdata,
   input  logic [3:0]  s1_mem_wstrb,
   output logic        s1_mem_ready,
   output logic [31:0] s1_mem_rdata,
   output logic        s1_mem_err,

   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,

   output logic        grant,
   output logic        busy
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          grant_q, grant_d;

   logic          mem_valid_q, mem_valid_d;
   logic          mem_instr_q, mem_instr_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]    mem_wstrb_q, mem_wstrb_d;

   logic          s0_ready_q, s0_ready_d;
   logic          s0_err_q, s0_err_d;
   logic [31:0]   s0_rdata_q, s0_rdata_d;
   logic          s1_ready_q, s1_ready_d;
   logic          s1_err_q, s1_err_d;
   logic [31:0]   s1_rdata_q, s1_rdata_d;

   logic          win;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic          last_q, last_d;

   // On a tie the port that did not win last time goes first.
   always_comb begin
      if (s0_mem_valid && s1_mem_valid) win = ~last_q;
      else                              win = ~s0_mem_valid;
   end
`else
   always_comb win = ~s0_mem_valid;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      mem_valid_d = mem_valid_q;
      mem_instr_d = mem_instr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      s0_ready_d  = s0_ready_q;
      s0_err_d    = s0_err_q;
      s0_rdata_d  = s0_rdata_q;
      s1_ready_d  = s1_ready_q;
      s1_err_d    = s1_err_q;
      s1_rdata_d  = s1_rdata_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_d      = last_q;
`endif

      case (state_q)
         IDLE: begin
            if (s0_mem_valid || s1_mem_valid) begin
               grant_d     = win;
               mem_valid_d = 1'b1;
               mem_instr_d = win ? s1_mem_instr : s0_mem_instr;
               mem_addr_d  = win ? s1_mem_addr  : s0_mem_addr;
               mem_wdata_d = win ? s1_mem_wdata : s0_mem_wdata;
               mem_wstrb_d = win ? s1_mem_wstrb : s0_mem_wstrb;
               cnt_d       = '0;
               state_d     = BUSY;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
               last_d      = win;
`endif
            end
         end
         BUSY: begin
            // A ready arriving in the final watchdog cycle still wins over the timeout.
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               state_d     = RESP;
               if (grant_q) begin
                  s1_ready_d = 1'b1;
                  s1_rdata_d = mem_rdata;
               end else begin
                  s0_ready_d = 1'b1;
                  s0_rdata_d = mem_rdata;
               end
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LIM)) begin
               mem_valid_d = 1'b0;
               state_d     = RESP;
               if (grant_q) begin
                  s1_ready_d = 1'b1;
                  s1_err_d   = 1'b1;
                  s1_rdata_d = '0;
               end else begin
                  s0_ready_d = 1'b1;
                  s0_err_d   = 1'b1;
                  s0_rdata_d = '0;
               end
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            s0_ready_d = 1'b0;
            s0_err_d   = 1'b0;
            s0_rdata_d = '0;
            s1_ready_d = 1'b0;
            s1_err_d   = 1'b0;
            s1_rdata_d = '0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         grant_q     <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_instr_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         s0_ready_q  <= 1'b0;
         s0_err_q    <= 1'b0;
         s0_rdata_q  <= '0;
         s1_ready_q  <= 1'b0;
         s1_err_q    <= 1'b0;
         s1_rdata_q  <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         last_q      <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         mem_valid_q <= mem_valid_d;
         mem_instr_q <= mem_instr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         s0_ready_q  <= s0_ready_d;
         s0_err_q    <= s0_err_d;
         s0_rdata_q  <= s0_rdata_d;
         s1_ready_q  <= s1_ready_d;
         s1_err_q    <= s1_err_d;
         s1_rdata_q  <= s1_rdata_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         last_q      <= last_d;
`endif
      end
   end

   assign mem_valid    = mem_valid_q;
   assign mem_instr    = mem_instr_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_wstrb    = mem_wstrb_q;
   assign s0_mem_ready = s0_ready_q;
   assign s0_mem_err   = s0_err_q;
   assign s0_mem_rdata = s0_rdata_q;
   assign s1_mem_ready = s1_ready_q;
   assign s1_mem_err   = s1_err_q;
   assign s1_mem_rdata = s1_rdata_q;
   assign grant        = grant_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter against an arbitration/latency model
// Build option: MEM_ARBITER_ROUND_ROBIN_EN switches the expected tie-break policy.
module tb_mem_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        s0_mem_valid = 1'b0, s0_mem_instr = 1'b0;
   logic [31:0] s0_mem_addr = '0, s0_mem_wdata = '0;
   logic [3:0]  s0_mem_wstrb = '0;
   logic        s0_mem_ready, s0_mem_err;
   logic [31:0] s0_mem_rdata;
   logic        s1_mem_valid = 1'b0, s1_mem_instr = 1'b0;
   logic [31:0] s1_mem_addr = '0, s1_mem_wdata = '0;
   logic [3:0]  s1_mem_wstrb = '0;
   logic        s1_mem_ready, s1_mem_err;
   logic [31:0] s1_mem_rdata;
   logic        mem_valid, mem_instr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        grant, busy;

   int checks = 0;
   int failures = 0;
   int model_last = 1;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .s0_mem_valid(s0_mem_valid), .s0_mem_instr(s0_mem_instr), .s0_mem_addr(s0_mem_addr),
      .s0_mem_wdata(s0_mem_wdata), .s0_mem_wstrb(s0_mem_wstrb), .s0_mem_ready(s0_mem_ready),
      .s0_mem_rdata(s0_mem_rdata), .s0_mem_err(s0_mem_err),
      .s1_mem_valid(s1_mem_valid), .s1_mem_instr(s1_mem_instr), .s1_mem_addr(s1_mem_addr),
      .s1_mem_wdata(s1_mem_wdata), .s1_mem_wstrb(s1_mem_wstrb), .s1_mem_ready(s1_mem_ready),
      .s1_mem_rdata(s1_mem_rdata), .s1_mem_err(s1_mem_err),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .grant(grant), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Arbitration rule stated as policy, not as the design's state machine.
   function automatic int pick(input bit r0, input bit r1);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (r0 && r1) return (model_last == 1) ? 0 : 1;
`endif
      return r0 ? 0 : 1;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_valid"}, 32'(mem_valid), 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 0);
      chk({tag, "_grant"}, 32'(grant), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_s0_ready"}, 32'(s0_mem_ready), 0);
      chk({tag, "_s1_ready"}, 32'(s1_mem_ready), 0);
      chk({tag, "_s0_err"}, 32'(s0_mem_err), 0);
      chk({tag, "_s1_rdata"}, s1_mem_rdata, 0);
   endtask

   // One request round starting from IDLE at a falling edge; wt = BUSY cycle index of mem_ready.
   task automatic run_txn(input bit r0, input bit r1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [3:0] w0, input logic [3:0] w1,
                          input bit i0, input bit i1, input int wt, input logic [31:0] rd,
                          output int won);
      int          w, ridx;
      bit          e;
      logic [31:0] ea, ed, erd;
      logic [3:0]  ews;
      bit          ei;
      w   = pick(r0, r1);
      ea  = w ? a1 : a0;
      ed  = w ? d1 : d0;
      ews = w ? w1 : w0;
      ei  = w ? i1 : i0;
      e    = (wt >= TO);
      ridx = e ? TO - 1 : wt;
      erd  = e ? 32'h0 : rd;

      s0_mem_valid = r0; s0_mem_addr = a0; s0_mem_wdata = d0; s0_mem_wstrb = w0; s0_mem_instr = i0;
      s1_mem_valid = r1; s1_mem_addr = a1; s1_mem_wdata = d1; s1_mem_wstrb = w1; s1_mem_instr = i1;
      @(negedge clk);
      chk("req_mem_valid", 32'(mem_valid), 1);
      chk("req_grant", 32'(grant), 32'(w));
      chk("req_busy", 32'(busy), 1);
      chk("req_mem_addr", mem_addr, ea);
      chk("req_mem_wdata", mem_wdata, ed);
      chk("req_mem_wstrb", 32'(mem_wstrb), 32'(ews));
      chk("req_mem_instr", 32'(mem_instr), 32'(ei));

      for (int k = 0; k <= ridx; k++) begin
         s0_mem_addr  = $urandom;
         s1_mem_addr  = $urandom;
         s0_mem_wstrb = 4'($urandom);
         s1_mem_wdata = $urandom;
         mem_ready    = (k == wt);
         mem_rdata    = (k == wt) ? rd : $urandom;
         @(negedge clk);
         if (k < ridx) begin
            chk("wait_mem_valid", 32'(mem_valid), 1);
            chk("wait_mem_addr_held", mem_addr, ea);
            chk("wait_mem_wstrb_held", 32'(mem_wstrb), 32'(ews));
            chk("wait_s0_ready", 32'(s0_mem_ready), 0);
            chk("wait_s1_ready", 32'(s1_mem_ready), 0);
         end else begin
            chk("resp_mem_valid", 32'(mem_valid), 0);
            chk("resp_busy", 32'(busy), 1);
            chk("resp_win_ready", 32'(w ? s1_mem_ready : s0_mem_ready), 1);
            chk("resp_win_err", 32'(w ? s1_mem_err : s0_mem_err), 32'(e));
            chk("resp_win_rdata", w ? s1_mem_rdata : s0_mem_rdata, erd);
            chk("resp_lose_ready", 32'(w ? s0_mem_ready : s1_mem_ready), 0);
            chk("resp_lose_err", 32'(w ? s0_mem_err : s1_mem_err), 0);
            chk("resp_lose_rdata", w ? s0_mem_rdata : s1_mem_rdata, 0);
         end
      end

      mem_ready = 1'b0;
      if (w == 0) s0_mem_valid = 1'b0;
      else        s1_mem_valid = 1'b0;
      @(negedge clk);
      chk("idle_s0_ready", 32'(s0_mem_ready), 0);
      chk("idle_s1_ready", 32'(s1_mem_ready), 0);
      chk("idle_err", 32'({s0_mem_err, s1_mem_err}), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_mem_valid", 32'(mem_valid), 0);
      chk("idle_grant", 32'(grant), 32'(w));
      model_last = w;
      won = w;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      s0_mem_valid = 1'b0; s1_mem_valid = 1'b0; mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_last = 1;
      @(negedge clk);
   endtask

   int won;
   int tie_exp[4];

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // Stray mem_ready while idle is ignored
      mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      repeat (2) @(negedge clk);
      mem_ready = 1'b0;
      chk("stray_busy", 32'(busy), 0);
      chk("stray_s0_ready", 32'(s0_mem_ready), 0);
      chk("stray_s1_ready", 32'(s1_mem_ready), 0);

      // Port-0 read, memory answers one cycle later
      run_txn(1, 0, 32'h100, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1, 0, 1, 32'hDEADBEEF, won);
      chk("p0_read_winner", 32'(won), 0);

      // Port-1 write
      run_txn(0, 1, 32'h0, 32'h200, 32'h0, 32'h12345678, 4'h0, 4'hF, 0, 0, 0, 32'h0, won);
      chk("p1_write_winner", 32'(won), 1);

      // Four tie rounds from reset
      do_reset();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      tie_exp = '{0, 1, 0, 1};
`else
      tie_exp = '{0, 0, 0, 0};
`endif
      for (int r = 0; r < 4; r++) begin
         run_txn(1, 1, 32'h1000 + 32'(r), 32'h2000 + 32'(r), $urandom, $urandom,
                 4'($urandom), 4'($urandom), 0, 1, r, $urandom, won);
         chk("tie_round_grant", 32'(won), 32'(tie_exp[r]));
      end

      // Watchdog: never ready, then ready in the last allowed cycle
      run_txn(1, 0, 32'h300, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 0, 100, 32'h0, won);
      run_txn(1, 0, 32'h304, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 0, TO - 1, 32'h5A5A5A5A, won);

      // Reset during BUSY abandons the transaction
      s0_mem_valid = 1'b1; s0_mem_addr = 32'h400; s0_mem_wstrb = 4'h0;
      repeat (2) @(negedge clk);
      chk("mid_busy_before", 32'(busy), 1);
      reset_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      s0_mem_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      model_last = 1;
      @(negedge clk);
      chk_all_zero("midrst_after");
      run_txn(0, 1, 32'h0, 32'h500, 32'h0, 32'hA5A5A5A5, 4'h0, 4'h3, 0, 0, 2, 32'h0, won);
      chk("midrst_s1_winner", 32'(won), 1);

      // Randomized rounds against the model
      for (int n = 0; n < 60; n++) begin
         bit r0, r1;
         r0 = 1'($urandom);
         r1 = 1'($urandom);
         if (!r0 && !r1) r1 = 1'b1;
         run_txn(r0, r1, $urandom, $urandom, $urandom, $urandom, 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), int'($urandom_range(0, 6)), $urandom, won);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one picorv32-style memory port between masters, e.g. the core's instruction/data traffic and a loader/debug master. Each upstream port is a slave with the native valid/ready interface; the downstream port drives the single memory. The arbiter:
- grants one transaction at a time and registers all forwarded signals;
- guards each transaction with a watchdog that returns an error response if memory never answers.

## Interface
- TIMEOUT, 255, max BUSY cycles waiting for `mem_ready`; 0 disables the watchdog.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s0_mem_valid`, `s1_mem_valid`  in  1  request from port 0/1.
- `s0_mem_instr`, `s1_mem_instr`  in  1  instruction-fetch flag.
- `s0_mem_addr`, `s1_mem_addr`  in  32  byte address.
- `s0_mem_wdata`, `s1_mem_wdata`  in  32  write data.
- `s0_mem_wstrb`, `s1_mem_wstrb`  in  4  byte strobes; 0000 = read.
- `s0_mem_ready`, `s1_mem_ready`  out  1  one-cycle completion pulse.
- `s0_mem_rdata`, `s1_mem_rdata`  out  32  read data, valid while ready.
- `s0_mem_err`, `s1_mem_err`  out  1  timeout pulse, coincident with ready.
- `mem_valid`, `mem_instr`  out  1  downstream request and fetch flag.
- `mem_addr`, `mem_wdata`  out  32  downstream address and write data.
- `mem_wstrb`  out  4  downstream strobes.
- `mem_ready`  in  1  downstream completion.
- `mem_rdata`  in  32  downstream read data.
- `grant`  out  1  port owning the current or last transaction.
- `busy`  out  1  high in BUSY and RESP.

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE:**
  - No valid request: stay in IDLE.
  - Any `sN_mem_valid` high: select a winner (see Configuration), set `grant`.
  - Latch the winner's instr/addr/wdata/wstrb onto `mem_*`, set `mem_valid`=1, clear the watchdog counter, go to BUSY.
- **BUSY:**
  - Downstream outputs are held stable.
  - `mem_ready`=1:
    - drive `mem_valid`<=0;
    - drive `sN_mem_rdata`<=`mem_rdata` and `sN_mem_ready`<=1 for the granted N;
    - go to RESP.
  - Otherwise, with TIMEOUT≠0 and counter==TIMEOUT-1:
    - drive `mem_valid`<=0;
    - drive `sN_mem_ready`<=1, `sN_mem_err`<=1, `sN_mem_rdata`<=0;
    - go to RESP.
  - Otherwise the counter increments.
- **RESP:**
  - Clear ready and err; go to IDLE.
  - The requester drops valid on the edge where it sees ready, so the old request is not re-arbitrated.
- Counter width is $clog2(TIMEOUT+1); it never wraps, because the timeout fires first.
- The non-granted port's ready, err and rdata stay 0 throughout.
- Upstream signals are sampled only in IDLE. Changes during BUSY are ignored.
- Write data is forwarded unmodified. Strobes are not realigned; address alignment is the requester's job.

## Timing
- All outputs reset to 0 asynchronously when `reset_n` falls: `mem_*`, `sN_mem_*`, `grant`, `busy`. State goes to IDLE. Internal last-grant resets to 1.
- Reset mid-transaction abandons the transaction; no ready or err is produced.
- Request seen at edge E: `mem_valid` is high after E. `mem_ready` sampled at edge F gives `sN_mem_ready` high for the cycle after F. Back in IDLE after F+1.
- Minimum request-to-ready is 2 edges.
- Back-to-back throughput: one transaction per 3 cycles plus memory wait states.
- `mem_ready` in the timeout cycle counts as success: no err.
- `mem_ready` seen outside BUSY is ignored.

## Configuration
- `MEM_ARBITER_ROUND_ROBIN_EN`:
  - Defined: when both ports request in IDLE, grant the port not granted last. A lone requester always wins and updates last-grant.
  - Undefined: port 0 has fixed priority; port 1 is granted only when `s0_mem_valid`=0.
  - Because last-grant resets to 1, the first tie after reset goes to port 0 in both builds.

## Test plan
- **Port-0 read:** s0 reads addr 0x100, memory returns 0xDEADBEEF with `mem_ready` 1 cycle later.
  - Expect: `mem_addr`=0x100, `mem_wstrb`=0; `s0_mem_ready` one cycle with rdata 0xDEADBEEF; `s1_mem_ready` stays 0.
- **Port-1 write:** s1 writes 0x12345678, wstrb 1111, to 0x200.
  - Expect: downstream carries identical fields; `grant`=1; `s1_mem_ready` pulses, `s1_mem_err`=0.
- **Simultaneous requests, 4 consecutive rounds:**
  - With the macro: grants 0,1,0,1.
  - Without the macro: grants 0,0,0,0 while s0 keeps requesting.
- **Timeout:** TIMEOUT=4, memory never ready.
  - Expect: `mem_valid` drops after 4 BUSY cycles; `s0_mem_ready`=`s0_mem_err`=1 for one cycle with rdata 0.
  - Same bench with `mem_ready` in cycle 4 gives err=0.
- **Reset mid-transaction:** `reset_n` pulled low during BUSY.
  - Expect: all outputs 0 immediately; after release, a new s1 request completes normally.
